// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES key-schedule tables, FSM states and C/D helpers
package des_pkg;

    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    // Entries are DES bit positions (1 = MSB) of the 64-bit key
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // Entries are positions (1 = MSB) within the 56-bit C||D word
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // SHIFT[r-1] is the left-rotate amount that produces round r's C/D
    localparam logic [1:0] SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        o = '0;
        for (int j = 0; j < 56; j++) begin
            o[55-j] = k[64-PC1[j]];
        end
        return o;
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] s,
                                          input logic right);
        logic [27:0] r;
        case ({right, s})
            3'b001:  r = {x[26:0], x[27]};
            3'b010:  r = {x[25:0], x[27:26]};
            3'b101:  r = {x[0], x[27:1]};
            3'b110:  r = {x[1:0], x[27:2]};
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic [1:0] s,
                                           input logic right);
        return {rot28(cd[55:28], s, right), rot28(cd[27:0], s, right)};
    endfunction

endpackage

// File: rtl/des_pc2.sv
// rtl/des_pc2.sv - combinational PC-2 selection of a 48-bit subkey from C||D
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd_i,
    output logic [47:0] subkey_o
);

    always_comb begin
        subkey_o = '0;
        for (int j = 0; j < 48; j++) begin
            subkey_o[47-j] = cd_i[56-PC2[j]];
        end
    end

endmodule

// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - streams the 16 DES round subkeys with valid/ready handshake
module des_key_schedule
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] key,
    input  logic        decrypt,
    input  logic        subkey_ready,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    output logic [3:0]  round,
    output logic        busy,
    output logic        done
);

    state_e      state_q;
    logic [55:0] cd_q, cd_d, cd_load;
    logic [47:0] subkey_q, pc2_out;
    logic [4:0]  rnd_q;
    logic        dec_q, valid_q, busy_q, done_q;
    logic        load, accept, last;
    logic [3:0]  enc_idx, dec_idx;

    assign enc_idx = rnd_q[3:0];
    assign dec_idx = 4'(rnd_q - 5'd1);

    always_comb begin
        cd_load = pc1(key);
        load    = (state_q == ST_IDLE) && start;
        accept  = (state_q == ST_RUN) && valid_q && subkey_ready;
        last    = dec_q ? (rnd_q == 5'd1) : (rnd_q == 5'd16);
        cd_d    = cd_q;
        if (load) begin
            cd_d = decrypt ? cd_load : rot_cd(cd_load, 2'd1, 1'b0);
        end else if (accept) begin
            // Encrypt finishes at C16 = C0 already; decrypt needs its last right-rotate
            if (dec_q) begin
                cd_d = rot_cd(cd_q, SHIFT[dec_idx], 1'b1);
            end else if (!last) begin
                cd_d = rot_cd(cd_q, SHIFT[enc_idx], 1'b0);
            end
        end
    end

    des_pc2 u_pc2 (
        .cd_i     (cd_d),
        .subkey_o (pc2_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cd_q     <= '0;
            subkey_q <= '0;
            rnd_q    <= '0;
            dec_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            cd_q   <= cd_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q  <= ST_RUN;
                        dec_q    <= decrypt;
                        rnd_q    <= decrypt ? 5'd16 : 5'd1;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        subkey_q <= pc2_out;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (last) begin
                            state_q  <= ST_IDLE;
                            valid_q  <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            rnd_q    <= '0;
                            subkey_q <= '0;
                        end else begin
                            rnd_q    <= dec_q ? rnd_q - 5'd1 : rnd_q + 5'd1;
                            subkey_q <= pc2_out;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Round 16 is presented as 4'd0 on the 4-bit port; subkey_valid qualifies it
    assign subkey       = subkey_q;
    assign subkey_valid = valid_q;
    assign round        = rnd_q[3:0];
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// tb/tb_des_key_schedule.sv - directed scoreboard bench for des_key_schedule
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst, start, decrypt, subkey_ready;
    logic [63:0] key;
    logic [47:0] subkey;
    logic        subkey_valid, busy, done;
    logic [3:0]  round;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0]  rnd;
        logic [47:0] sk;
    } exp_t;

    exp_t sb[$];

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_P = 64'h123556789ABDDEF0;

    logic [47:0] kref [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    always #5 clk = ~clk;

    des_key_schedule dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .key          (key),
        .decrypt      (decrypt),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .round        (round),
        .busy         (busy),
        .done         (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input bit dec);
        for (int i = 0; i < 16; i++) begin
            int idx;
            idx = dec ? 15 - i : i;
            sb.push_back({4'(idx + 1), kref[idx]});
        end
    endtask

    task automatic consume(input bit rnd_ready, input int n);
        int          got = 0;
        int          cyc = 0;
        bit          hold = 0;
        logic [47:0] hsk = '0;
        logic [3:0]  hr = '0;
        exp_t        e;
        while (got < n && sb.size() > 0 && cyc < 400) begin
            subkey_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            check("valid_in_seq", 64'(subkey_valid), 64'd1);
            check("busy_in_seq", 64'(busy), 64'd1);
            if (hold) begin
                check("hold_subkey", 64'(subkey), 64'(hsk));
                check("hold_round", 64'(round), 64'(hr));
            end
            if (subkey_ready && subkey_valid) begin
                e = sb.pop_front();
                check("subkey", 64'(subkey), 64'(e.sk));
                check("round", 64'(round), 64'(e.rnd));
                got++;
                hold = 0;
            end else begin
                hold = 1;
                hsk  = subkey;
                hr   = round;
            end
            @(negedge clk);
            cyc++;
        end
        if (got < n) begin
            checks++;
            failures++;
            $display("FAIL consume_timeout got=%0d required=%0d", got, n);
        end
    endtask

    task automatic check_done();
        check("done_pulse", 64'(done), 64'd1);
        check("done_valid", 64'(subkey_valid), 64'd0);
        check("done_busy", 64'(busy), 64'd0);
        check("done_subkey", 64'(subkey), 64'd0);
        check("done_round", 64'(round), 64'd0);
    endtask

    task automatic start_seq(input logic [63:0] k, input bit dec);
        start   = 1'b1;
        key     = k;
        decrypt = dec;
        push_seq(dec);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; decrypt = 1'b0; subkey_ready = 1'b0; key = '0;
        repeat (2) @(negedge clk);
        check("rst_subkey", 64'(subkey), 64'd0);
        check("rst_valid", 64'(subkey_valid), 64'd0);
        check("rst_round", 64'(round), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Encrypt, ready always high
        subkey_ready = 1'b1;
        start_seq(KEY_A, 1'b0);
        consume(1'b0, 16);
        check_done();
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);

        // Decrypt order
        start_seq(KEY_A, 1'b1);
        consume(1'b0, 16);
        check_done();
        @(negedge clk);

        // Random backpressure; key/decrypt changes while busy must not matter
        start_seq(KEY_A, 1'b0);
        key     = 64'hFFFF_0000_A5A5_5A5A;
        decrypt = 1'b1;
        consume(1'b1, 16);
        check_done();
        @(negedge clk);

        // Parity bits ignored
        start_seq(KEY_P, 1'b0);
        consume(1'b1, 16);
        check_done();
        @(negedge clk);

        // Reset after the 7th acceptance aborts the sequence
        start_seq(KEY_A, 1'b0);
        consume(1'b0, 7);
        rst = 1'b1;
        #1;
        check("abort_subkey", 64'(subkey), 64'd0);
        check("abort_valid", 64'(subkey_valid), 64'd0);
        check("abort_round", 64'(round), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort_no_done", 64'(done), 64'd0);
        check("abort_idle_valid", 64'(subkey_valid), 64'd0);
        start_seq(KEY_A, 1'b0);
        consume(1'b0, 16);
        check_done();
        @(negedge clk);

        // start held high: accepted again on the done cycle, ignored while busy
        start   = 1'b1;
        key     = KEY_A;
        decrypt = 1'b0;
        push_seq(1'b0);
        @(negedge clk);
        consume(1'b0, 16);
        check_done();
        push_seq(1'b0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_no_gap_valid", 64'(subkey_valid), 64'd1);
        check("b2b_done_low", 64'(done), 64'd0);
        consume(1'b0, 16);
        check_done();
        @(negedge clk);
        check("final_idle_busy", 64'(busy), 64'd0);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
